// File: rtl/wb_master_seq_pkg.sv
// Shared definitions for the Wishbone single-transfer master sequencer:
// state encodings and the default value returned on an ACK timeout.
package wb_master_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } seq_state_t;

  localparam logic [31:0] TIMEOUT_READ_VALUE_DEFAULT = 32'hBAD_FAB_AC;

endpackage

// File: rtl/wb_master_seq.sv
// Command/response to Wishbone master bridge: one bus transfer per command,
// with a bounded wait for ACK that returns an error response on expiry.
module wb_master_seq
  import wb_master_seq_pkg::*;
#(
  parameter int unsigned ADDRWIDTH          = 17,
  parameter int unsigned DATAWIDTH          = 32,
  parameter int unsigned TIMEOUT_CNTR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_READ_VALUE = DATAWIDTH'(TIMEOUT_READ_VALUE_DEFAULT)
) (
  input  logic                   WBs_CLK_i,
  input  logic                   WBs_RST_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [ADDRWIDTH-1:0]   cmd_adr_i,
  input  logic [DATAWIDTH/8-1:0] cmd_byte_stb_i,
  input  logic [DATAWIDTH-1:0]   cmd_dat_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATAWIDTH-1:0]   rsp_dat_o,
  output logic                   rsp_err_o,
  output logic [ADDRWIDTH-1:0]   WBs_ADR_o,
  output logic                   WBs_CYC_o,
  output logic                   WBs_STB_o,
  output logic                   WBs_WE_o,
  output logic                   WBs_RD_o,
  output logic [DATAWIDTH/8-1:0] WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0]   WBs_DAT_o,
  input  logic [DATAWIDTH-1:0]   WBs_DAT_i,
  input  logic                   WBs_ACK_i,
  output logic                   busy_o
);

  localparam int unsigned BEW = DATAWIDTH / 8;
  localparam int unsigned TCW = TIMEOUT_CNTR_WIDTH;
  localparam logic [TCW-1:0] TIMEOUT_LIMIT = TCW'(TIMEOUT_CYCLES);

  // The wait counter must reach its limit without wrapping.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > ((1 << TCW) - 1)) begin : g_bad_timeout
    $error("wb_master_seq: TIMEOUT_CYCLES must be in 1 .. 2**TIMEOUT_CNTR_WIDTH-1");
  end

  seq_state_t state, state_next;

  logic [TCW-1:0]       cnt, cnt_d, cnt_inc;
  logic                 ready_d, busy_d;
  logic                 cyc_d, stb_d, we_d, rd_d;
  logic [ADDRWIDTH-1:0] adr_d;
  logic [BEW-1:0]       bstb_d;
  logic [DATAWIDTH-1:0] wdat_d;
  logic                 rsp_valid_d, rsp_err_d;
  logic [DATAWIDTH-1:0] rsp_dat_d;

  assign cnt_inc = cnt + TCW'(1);

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) state <= ST_IDLE;
    else           state <= state_next;
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_next  = state;
    cnt_d       = cnt;
    ready_d     = 1'b0;
    cyc_d       = 1'b0;
    stb_d       = 1'b0;
    we_d        = 1'b0;
    rd_d        = 1'b0;
    adr_d       = WBs_ADR_o;
    bstb_d      = WBs_BYTE_STB_o;
    wdat_d      = WBs_DAT_o;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_o;
    rsp_err_d   = rsp_err_o;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          state_next = ST_BUS;
          cnt_d      = '0;
          adr_d      = cmd_adr_i;
          bstb_d     = cmd_byte_stb_i;
          wdat_d     = cmd_dat_i;
          cyc_d      = 1'b1;
          stb_d      = 1'b1;
          we_d       = cmd_we_i;
          rd_d       = ~cmd_we_i;
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_BUS: begin
        // ACK takes priority over a timeout landing on the same cycle.
        if (WBs_ACK_i) begin
          state_next  = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = WBs_WE_o ? '0 : WBs_DAT_i;
          rsp_err_d   = 1'b0;
        end else if (cnt_inc == TIMEOUT_LIMIT) begin
          state_next  = ST_RESP;
          cnt_d       = cnt_inc;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = TIMEOUT_READ_VALUE;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = WBs_WE_o;
          rd_d  = WBs_RD_o;
        end
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          state_next = ST_IDLE;
          ready_d    = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    busy_d = (state_next != ST_IDLE);
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      cnt            <= '0;
      cmd_ready_o    <= 1'b0;
      busy_o         <= 1'b0;
      WBs_CYC_o      <= 1'b0;
      WBs_STB_o      <= 1'b0;
      WBs_WE_o       <= 1'b0;
      WBs_RD_o       <= 1'b0;
      WBs_ADR_o      <= '0;
      WBs_BYTE_STB_o <= '0;
      WBs_DAT_o      <= '0;
      rsp_valid_o    <= 1'b0;
      rsp_dat_o      <= '0;
      rsp_err_o      <= 1'b0;
    end else begin
      cnt            <= cnt_d;
      cmd_ready_o    <= ready_d;
      busy_o         <= busy_d;
      WBs_CYC_o      <= cyc_d;
      WBs_STB_o      <= stb_d;
      WBs_WE_o       <= we_d;
      WBs_RD_o       <= rd_d;
      WBs_ADR_o      <= adr_d;
      WBs_BYTE_STB_o <= bstb_d;
      WBs_DAT_o      <= wdat_d;
      rsp_valid_o    <= rsp_valid_d;
      rsp_dat_o      <= rsp_dat_d;
      rsp_err_o      <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Directed bench for wb_master_seq: a transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_wb_master_seq;

  localparam int unsigned TO     = 255;
  localparam int unsigned BUDGET = 700;
  localparam logic [31:0] TOV    = 32'hBAD_FAB_AC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [16:0] cmd_adr_i = '0;
  logic [3:0]  cmd_byte_stb_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic [16:0] WBs_ADR_o;
  logic        WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o;
  logic [3:0]  WBs_BYTE_STB_o;
  logic [31:0] WBs_DAT_o, WBs_DAT_i = '0;
  logic        WBs_ACK_i = 1'b0;
  logic        busy_o;

  wb_master_seq dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_byte_stb_i(cmd_byte_stb_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .WBs_ADR_o(WBs_ADR_o), .WBs_CYC_o(WBs_CYC_o), .WBs_STB_o(WBs_STB_o),
    .WBs_WE_o(WBs_WE_o), .WBs_RD_o(WBs_RD_o), .WBs_BYTE_STB_o(WBs_BYTE_STB_o),
    .WBs_DAT_o(WBs_DAT_o), .WBs_DAT_i(WBs_DAT_i), .WBs_ACK_i(WBs_ACK_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_no++;

  // Slave: ACK on the ack_after-th bus cycle (0 = never); stray ACK outside cycles.
  int          ack_after  = 0;
  int          bus_cnt    = 0;
  logic        stray_ack  = 1'b0;
  logic [31:0] slave_data = '0;

  always @(negedge clk) begin
    if (WBs_CYC_o) bus_cnt++;
    else           bus_cnt = 0;
    WBs_ACK_i = WBs_CYC_o ? (ack_after != 0 && bus_cnt == ack_after) : stray_ack;
    WBs_DAT_i = slave_data;
  end

  // Reference model: a command occupies the bus for a number of cycles, then
  // leaves one response in a queue until the consumer takes it.
  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  rsp_t        q[$];
  logic        m_ready = 1'b0, m_bus = 1'b0, m_we = 1'b0;
  int          m_age = 0;
  logic [16:0] m_adr = '0;
  logic [3:0]  m_bstb = '0;
  logic [31:0] m_wdat = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b0; m_bus = 1'b0; m_age = 0; q.delete();
    end else if (m_bus) begin
      m_age++;
      if (WBs_ACK_i) begin
        q.push_back('{m_we ? 32'h0 : WBs_DAT_i, 1'b0});
        m_bus = 1'b0;
      end else if (m_age == TO) begin
        q.push_back('{TOV, 1'b1});
        m_bus = 1'b0;
      end
    end else if (q.size() != 0) begin
      if (rsp_ready_i) begin
        void'(q.pop_front());
        m_ready = 1'b1;
      end
    end else if (m_ready && cmd_valid_i) begin
      m_bus = 1'b1; m_age = 0; m_ready = 1'b0;
      m_we = cmd_we_i; m_adr = cmd_adr_i; m_bstb = cmd_byte_stb_i; m_wdat = cmd_dat_i;
    end else begin
      m_ready = 1'b1;
    end
  end

  int cyc_hi = 0;
  int we_hi  = 0;

  always @(negedge clk) begin
    chk("cmd_ready", 64'(cmd_ready_o), 64'(m_ready));
    chk("busy", 64'(busy_o), 64'(m_bus || q.size() != 0));
    chk("cyc", 64'(WBs_CYC_o), 64'(m_bus));
    chk("stb", 64'(WBs_STB_o), 64'(m_bus));
    chk("we", 64'(WBs_WE_o), 64'(m_bus && m_we));
    chk("rd", 64'(WBs_RD_o), 64'(m_bus && !m_we));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(q.size() != 0));
    if (m_bus) begin
      chk("adr", 64'(WBs_ADR_o), 64'(m_adr));
      chk("byte_stb", 64'(WBs_BYTE_STB_o), 64'(m_bstb));
      chk("wdat", 64'(WBs_DAT_o), 64'(m_wdat));
    end
    if (q.size() != 0) begin
      chk("rsp_dat", 64'(rsp_dat_o), 64'(q[0].dat));
      chk("rsp_err", 64'(rsp_err_o), 64'(q[0].err));
    end
    if (WBs_CYC_o) cyc_hi++;
    if (WBs_WE_o)  we_hi++;
  end

  int          acc_cycle, rsp_cycle, done_cycle, rdy_seen;
  logic [31:0] got_dat;
  logic        got_err;

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic do_cmd(input logic we, input logic [16:0] adr,
                        input logic [31:0] dat, input logic [3:0] bstb);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr;
    cmd_dat_i = dat; cmd_byte_stb_i = bstb;
    while (!cmd_ready_o && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < BUDGET), 64'(1));
    acc_cycle = cyc_no;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int hold);
    int n = 0;
    while (!rsp_valid_o && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", 64'(n < BUDGET), 64'(1));
    rsp_cycle = cyc_no;
    got_dat = rsp_dat_o;
    got_err = rsp_err_o;
    rdy_seen = 0;
    for (int i = 0; i < hold; i++) begin
      if (cmd_ready_o) rdy_seen++;
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    done_cycle = cyc_no;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cyc", 64'(WBs_CYC_o), 64'(0));
    chk("rst_stb", 64'(WBs_STB_o), 64'(0));
    chk("rst_we_rd", 64'({WBs_WE_o, WBs_RD_o}), 64'(0));
    chk("rst_adr", 64'(WBs_ADR_o), 64'(0));
    chk("rst_bstb", 64'(WBs_BYTE_STB_o), 64'(0));
    chk("rst_wdat", 64'(WBs_DAT_o), 64'(0));
    chk("rst_rsp", 64'({rsp_valid_o, rsp_err_o}), 64'(0));
    chk("rst_rsp_dat", 64'(rsp_dat_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ready", 64'(cmd_ready_o), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(cmd_ready_o), 64'(1));

    // Stray ACK while idle must be ignored.
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;

    // Write, ACK on third bus cycle.
    ack_after = 3; slave_data = 32'hDEAD_BEEF; we_hi = 0;
    do_cmd(1'b1, 17'h01004, 32'hA5A5_0001, 4'hF);
    wait_rsp(0);
    chk("wr_we_cycles", 64'(we_hi), 64'(3));
    chk("wr_rsp_dat", 64'(got_dat), 64'(0));
    chk("wr_rsp_err", 64'(got_err), 64'(0));

    // Read with ACK on first bus cycle: minimum latency.
    ack_after = 1; slave_data = 32'h0000_0A1B;
    do_cmd(1'b0, 17'h00000, 32'h0, 4'hF);
    wait_rsp(0);
    chk("rd_latency", 64'(rsp_cycle - acc_cycle), 64'(2));
    chk("rd_rsp_dat", 64'(got_dat), 64'(32'h0000_0A1B));
    chk("rd_rsp_err", 64'(got_err), 64'(0));

    // Read without ACK: timeout.
    ack_after = 0; slave_data = 32'h1111_2222; cyc_hi = 0;
    do_cmd(1'b0, 17'h1FFFC, 32'h0, 4'h3);
    wait_rsp(0);
    chk("to_cyc_cycles", 64'(cyc_hi), 64'(255));
    chk("to_rsp_dat", 64'(got_dat), 64'(32'hBADFABAC));
    chk("to_rsp_err", 64'(got_err), 64'(1));

    // ACK on the final allowed cycle wins over timeout.
    ack_after = 255; slave_data = 32'h1234_5678; cyc_hi = 0;
    do_cmd(1'b0, 17'h00200, 32'h0, 4'hC);
    wait_rsp(0);
    chk("ackto_cyc_cycles", 64'(cyc_hi), 64'(255));
    chk("ackto_rsp_dat", 64'(got_dat), 64'(32'h1234_5678));
    chk("ackto_rsp_err", 64'(got_err), 64'(0));

    // Response held 10 cycles with a second command pending.
    ack_after = 2; slave_data = 32'h0BAD_F00D;
    do_cmd(1'b0, 17'h00010, 32'h0, 4'hF);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 17'h00014;
    cmd_dat_i = 32'h5555_AAAA; cmd_byte_stb_i = 4'h6;
    stray_ack = 1'b1;
    wait_rsp(10);
    stray_ack = 1'b0;
    chk("hold_ready_seen", 64'(rdy_seen), 64'(0));
    chk("hold_rsp_dat", 64'(got_dat), 64'(32'h0BAD_F00D));
    do_cmd(1'b1, 17'h00014, 32'h5555_AAAA, 4'h6);
    chk("second_accept_cycle", 64'(acc_cycle - done_cycle), 64'(1));
    wait_rsp(0);
    chk("second_rsp_dat", 64'(got_dat), 64'(0));

    // Reset pulse in the middle of a bus cycle.
    ack_after = 0;
    do_cmd(1'b0, 17'h00020, 32'h0, 4'hF);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc_stb", 64'({WBs_CYC_o, WBs_STB_o}), 64'(0));
    chk("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ack_after = 1; slave_data = 32'hCAFE_0042;
    do_cmd(1'b0, 17'h00040, 32'h0, 4'hF);
    wait_rsp(0);
    chk("post_rst_rsp_dat", 64'(got_dat), 64'(32'hCAFE_0042));
    chk("post_rst_rsp_err", 64'(got_err), 64'(0));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
